instr_mem_32: RTL

- Instruction memory: the responder at the other end of the PC fetch interface.
- Returns the 32-bit instruction word for the byte address driven by the PC, read within the same cycle as the single-cycle core requires.
- Holds a byte-serial program loader FSM that fills the word array from a testbench or boot source before the core runs.
- Flags misaligned and out-of-range fetches.

---
 rtl/instr_mem_32.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_32.sv
// Instruction memory for a single-cycle core.
// The fetch read is combinational because the core needs the word in the same cycle
// that the PC presents the address.
// A byte-serial loader fills the word array before the core runs. Bytes arrive
// big-endian within each word.
module instr_mem_32 #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    addr,
    output logic [31:0]                    instruction,
    output logic                           fetch_err,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic [7:0]                     load_byte,
    input  logic                           load_last,
    output logic                           load_ready,
    output logic                           load_done,
    output logic                           load_ovf,
    output logic                           busy,
    output logic [$clog2(DEPTH_WORDS):0]   word_count
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [1:0]     byte_cnt_reg, byte_cnt_next;
    logic [31:0]    shift_reg, shift_next;
    logic [AW:0]    word_count_reg, word_count_next;
    logic           load_done_reg, load_done_next;
    logic           load_ovf_reg, load_ovf_next;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept;
    logic           word_write;
    logic [31:0]    assembled;
    logic           addr_aligned;
    logic           addr_in_range;

    assign accept     = load_valid && (state_reg == ST_LOAD);
    assign word_write = accept && ((byte_cnt_reg == 2'd3) || load_last);

    // The incoming byte replaces the lane selected by byte_cnt. The shift register is
    // cleared at the start of every word, so the unfilled low lanes of a partial
    // word are already zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign assembled[31-8*gi -: 8] = (byte_cnt_reg == 2'(gi)) ? load_byte
                                                                     : shift_reg[31-8*gi -: 8];
        end
    endgenerate

    // Decode the fetch address. DEPTH_WORDS is a power of two, so the range test
    // reduces to checking that the upper address bits are zero.
    assign addr_aligned  = (addr[1:0] == 2'b00);
    assign addr_in_range = (addr[31:AW+2] == '0);

    // Fetch path: serve words only in RUN. Any bad fetch returns the NOP word.
    always_comb begin
        instruction = NOP_WORD;
        fetch_err   = 1'b0;
        if (state_reg == ST_RUN) begin
            if (addr_aligned && addr_in_range) begin
                instruction = mem[addr[2 +: AW]];
            end else begin
                fetch_err = 1'b1;
            end
        end
    end

    // Loader next state: assemble bytes into words and decide when the load ends.
    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        byte_cnt_next   = byte_cnt_reg;
        shift_next      = shift_reg;
        word_count_next = word_count_reg;
        load_done_next  = 1'b0;
        load_ovf_next   = load_ovf_reg;
        case (state_reg)
            ST_RUN: begin
                if (load_start) begin
                    state_next    = ST_LOAD;
                    wr_ptr_next   = '0;
                    byte_cnt_next = 2'd0;
                    shift_next    = 32'h0;
                    load_ovf_next = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (word_write) begin
                        wr_ptr_next   = wr_ptr_reg + 1'b1;
                        byte_cnt_next = 2'd0;
                        shift_next    = 32'h0;
                        if (load_last) begin
                            state_next      = ST_RUN;
                            word_count_next = {1'b0, wr_ptr_reg} + (AW+1)'(1);
                            load_done_next  = 1'b1;
                        end else if (wr_ptr_reg == AW'(DEPTH_WORDS - 1)) begin
                            state_next      = ST_RUN;
                            word_count_next = (AW+1)'(DEPTH_WORDS);
                            load_ovf_next   = 1'b1;
                            load_done_next  = 1'b1;
                        end
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                        shift_next    = assembled;
                    end
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Loader state registers. Reset aborts any load in progress and drops a partial word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_RUN;
            wr_ptr_reg     <= '0;
            byte_cnt_reg   <= 2'd0;
            shift_reg      <= 32'h0;
            word_count_reg <= '0;
            load_done_reg  <= 1'b0;
            load_ovf_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            byte_cnt_reg   <= byte_cnt_next;
            shift_reg      <= shift_next;
            word_count_reg <= word_count_next;
            load_done_reg  <= load_done_next;
            load_ovf_reg   <= load_ovf_next;
        end
    end

    // Word array write port. Only the loader writes it, and reset never clears it.
    always_ff @(posedge clk) begin
        if (reset && word_write) begin
            mem[wr_ptr_reg] <= assembled;
        end
    end

    assign busy       = (state_reg == ST_LOAD);
    assign load_ready = (state_reg == ST_LOAD);
    assign load_done  = load_done_reg;
    assign load_ovf   = load_ovf_reg;
    assign word_count = word_count_reg;

endmodule
